// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single regfile write port, with a built-in zero-fill sweep.
// Grant is combinational; the regfile write lands one cycle after the handshake.
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  output logic [$clog2(NREQ)-1:0]  rf_wsrc
);

  localparam int SW = $clog2(NREQ);
  localparam logic [SW:0]   NREQ_W = (SW+1)'(NREQ);
  localparam logic [SW-1:0] LAST   = SW'(NREQ - 1);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q,    state_d;
  logic [SW-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [AW-1:0]   clr_cnt_q,  clr_cnt_d;
  logic            clr_busy_q, clr_busy_d;
  logic            rf_we_q,    rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [SW-1:0]   rf_wsrc_q,  rf_wsrc_d;

  logic            grant_found;
  logic [SW-1:0]   grant_idx;
  logic [SW:0]     cand;

  // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!grant_found && req_valid[cand[SW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    clr_busy_d = clr_busy_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_wsrc_d  = rf_wsrc_q;
    req_ready  = '0;

    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          clr_busy_d = 1'b1;
        end else if (grant_found) begin
          req_ready  = NREQ'(1) << grant_idx;
          rf_we_d    = 1'b1;
          rf_waddr_d = req_addr[grant_idx*AW +: AW];
          rf_wdata_d = req_data[grant_idx*DW +: DW];
          rf_wsrc_d  = grant_idx;
          rr_ptr_d   = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
      end
      CLEAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = clr_cnt_q;
        rf_wdata_d = '0;
        rf_wsrc_d  = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        // Leaving on the last address stops the counter wrap from starting a second sweep.
        if (clr_cnt_q == '1) begin
          state_d    = ARB;
          clr_busy_d = 1'b0;
        end
      end
      default: state_d = ARB;
    endcase

    if (!rst_n) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_wsrc_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_wsrc_q  <= rf_wsrc_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_wsrc  = rf_wsrc_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table for arbitration, hand sequences for clear sweeps.
module tb_rf_write_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                clr_start;
  logic                clr_busy;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;
  logic [1:0]          rf_wsrc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wsrc   (rf_wsrc)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_wsrc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Requester i sees addr^i and data^i, so the written values identify the granted requester.
  task automatic drive(input logic [3:0] v, input logic [4:0] a, input logic [31:0] d,
                       input logic clr);
    req_valid = v;
    clr_start = clr;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a ^ 5'(i);
      req_data[i*DW +: DW] = d ^ 32'(i);
    end
  endtask

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [4:0] a, logic [31:0] d,
                              logic [3:0] er, logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic [1:0] es);
    vec_t t;
    t.rst = rst; t.valid = v; t.addr = a; t.data = d;
    t.exp_ready = er; t.exp_we = ew; t.exp_waddr = ea; t.exp_wdata = ed; t.exp_wsrc = es;
    return t;
  endfunction

  // Clear sweep with requester 3 waiting; optional re-pulse of clr_start or reset mid-sweep.
  task automatic sweep(input int pulse_at, input int abort_at,
                       input logic [4:0] prev_waddr, input logic [31:0] prev_wdata);
    @(negedge clk);
    drive(4'b1000, 5'h1F, 32'hFFFF_FFFF, 1'b1);
    #1 chk("clr_start_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("clr_enter_busy", 32'(clr_busy), 32'h1);
    chk("clr_enter_we", 32'(rf_we), 32'h0);
    chk("clr_enter_waddr", 32'(rf_waddr), 32'(prev_waddr));
    chk("clr_enter_wdata", rf_wdata, prev_wdata);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      clr_start = (c == pulse_at);
      #1 chk($sformatf("clr%0d_ready", c), 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("clr%0d_we", c), 32'(rf_we), 32'h1);
      chk($sformatf("clr%0d_waddr", c), 32'(rf_waddr), 32'(c));
      chk($sformatf("clr%0d_wdata", c), rf_wdata, 32'h0);
      chk($sformatf("clr%0d_wsrc", c), 32'(rf_wsrc), 32'h0);
      chk($sformatf("clr%0d_busy", c), 32'(clr_busy), (c != 31) ? 32'h1 : 32'h0);
      if (c == abort_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'b0000, 5'h0, 32'h0, 1'b0);
        #1 chk("abort_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        chk("abort_we", 32'(rf_we), 32'h0);
        chk("abort_busy", 32'(clr_busy), 32'h0);
        chk("abort_waddr", 32'(rf_waddr), 32'h0);
        chk("abort_wdata", rf_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    drive(4'b1000, 5'h1F, 32'hFFFF_FFFF, 1'b0);
    #1 chk("post_clr_ready", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    chk("post_clr_we", 32'(rf_we), 32'h1);
    chk("post_clr_waddr", 32'(rf_waddr), 32'h1C);
    chk("post_clr_wdata", rf_wdata, 32'hFFFF_FFFC);
    chk("post_clr_wsrc", 32'(rf_wsrc), 32'h3);
    chk("post_clr_busy", 32'(clr_busy), 32'h0);
    @(negedge clk);
    drive(4'b0000, 5'h1F, 32'hFFFF_FFFF, 1'b0);
    #1 chk("idle_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("idle_we", 32'(rf_we), 32'h0);
    chk("idle_busy", 32'(clr_busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 5'h0, 32'h0, 1'b0);

    // rst, valid, addr, data, exp_ready, exp_we, exp_waddr, exp_wdata, exp_wsrc
    tbl.push_back(mk(1, 4'b0100, 5'h05, 32'hDEADBEED, 4'b0000, 0, 5'h00, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 4'b0100, 5'h05, 32'hDEADBEED, 4'b0100, 1, 5'h07, 32'hDEADBEEF, 2));
    tbl.push_back(mk(0, 4'b0000, 5'h05, 32'hDEADBEED, 4'b0000, 0, 5'h07, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 4'b1111, 5'h10, 32'h1000_0000, 4'b0000, 0, 5'h00, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b0001, 1, 5'h10, 32'h1000_0000, 0));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b0010, 1, 5'h11, 32'h1000_0001, 1));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b0100, 1, 5'h12, 32'h1000_0002, 2));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b1000, 1, 5'h13, 32'h1000_0003, 3));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b0001, 1, 5'h10, 32'h1000_0000, 0));
    tbl.push_back(mk(0, 4'b1111, 5'h10, 32'h1000_0000, 4'b0010, 1, 5'h11, 32'h1000_0001, 1));
    tbl.push_back(mk(0, 4'b0011, 5'h04, 32'hA5A5_0000, 4'b0001, 1, 5'h04, 32'hA5A5_0000, 0));
    tbl.push_back(mk(0, 4'b0011, 5'h04, 32'hA5A5_0000, 4'b0010, 1, 5'h05, 32'hA5A5_0001, 1));
    tbl.push_back(mk(0, 4'b0001, 5'h04, 32'hA5A5_0000, 4'b0001, 1, 5'h04, 32'hA5A5_0000, 0));
    tbl.push_back(mk(0, 4'b0011, 5'h04, 32'hA5A5_0000, 4'b0010, 1, 5'h05, 32'hA5A5_0001, 1));
    tbl.push_back(mk(0, 4'b1001, 5'h04, 32'hA5A5_0000, 4'b1000, 1, 5'h07, 32'hA5A5_0003, 3));
    tbl.push_back(mk(0, 4'b1001, 5'h04, 32'hA5A5_0000, 4'b0001, 1, 5'h04, 32'hA5A5_0000, 0));
    tbl.push_back(mk(0, 4'b0000, 5'h04, 32'hA5A5_0000, 4'b0000, 0, 5'h04, 32'hA5A5_0000, 0));

    foreach (tbl[n]) begin
      @(negedge clk);
      rst_n = !tbl[n].rst;
      drive(tbl[n].valid, tbl[n].addr, tbl[n].data, 1'b0);
      #1 chk($sformatf("row%0d_ready", n), 32'(req_ready), 32'(tbl[n].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("row%0d_we", n), 32'(rf_we), 32'(tbl[n].exp_we));
      chk($sformatf("row%0d_waddr", n), 32'(rf_waddr), 32'(tbl[n].exp_waddr));
      chk($sformatf("row%0d_wdata", n), rf_wdata, tbl[n].exp_wdata);
      chk($sformatf("row%0d_busy", n), 32'(clr_busy), 32'h0);
      if (tbl[n].exp_we) begin
        chk($sformatf("row%0d_wsrc", n), 32'(rf_wsrc), 32'(tbl[n].exp_wsrc));
      end
    end

    sweep(20, -1, 5'h04, 32'hA5A5_0000);
    sweep(-1, 10, 5'h1C, 32'hFFFF_FFFC);
    sweep(-1, -1, 5'h00, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
